mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data memory of the pipelined RISC-V core between the instruction-fetch stage and the load/store unit. It runs one transaction at a time through a small state machine. Load/store wins arbitration by default, with a bounded-starvation guarantee for fetch. A pipeline flush discards an in-flight fetch response. It sits between the core's IF/MEM stages and the memory model, and drives the grant/valid handshakes those stages stall on.

## Interface

- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, max consecutive load/store grants while fetch waits (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  pipeline flush from core (branch/jump redirect)
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  one-cycle pulse: fetch request accepted
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid
- if_rdata_o  out  DW  fetched instruction
- ls_req_i  in  1  load/store request; held with its fields until ls_gnt_o
- ls_we_i  in  1  1 = store
- ls_be_i  in  DW/8  byte enables
- ls_addr_i  in  AW  data address
- ls_wdata_i  in  DW  store data
- ls_gnt_o  out  1  one-cycle pulse: load/store accepted
- ls_rvalid_o  out  1  one-cycle pulse: load data / store ack
- ls_rdata_o  out  DW  load data
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/DW/8/AW/DW  memory command; mem_req_o held until mem_gnt_i
- mem_gnt_i  in  1  memory accepted command
- mem_rvalid_i  in  1  memory response (also acks stores)
- mem_rdata_i  in  DW  memory read data
- busy_o  out  1  state ≠ IDLE

## Operation

- States are IDLE, REQ and WAIT.
- IDLE:
  - If any request is eligible, arbitrate combinationally and pulse the winner's gnt_o in the same cycle.
  - Latch addr/we/be/wdata into command registers, plus owner (IF/LS) and drop = 0.
  - Go to REQ.
  - For a fetch, mem_we_o = 0 and mem_be_o = all ones.
- Arbitration:
  - LS wins if ls_req_i is high, unless if_req_i is high and starve_cnt == STARVE_MAX, in which case IF wins.
  - A fetch is not eligible in a cycle where flush_i is high; load/store is unaffected.
- starve_cnt has width $clog2(STARVE_MAX+1).
  - +1, saturating, when LS is granted while if_req_i is high.
  - Cleared when IF is granted, or when LS is granted with if_req_i low.
- REQ: mem_req_o = 1 and the command outputs are driven from registers. Move to WAIT on mem_gnt_i.
- WAIT:
  - On mem_rvalid_i, register mem_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o in the next cycle. Return to IDLE.
  - If owner = IF and drop = 1, suppress if_rvalid_o; the memory transaction still completes.
- Flush: drop is set when flush_i is high in REQ or WAIT while owner = IF. drop is cleared on the next grant.
- mem_rvalid_i is ignored in IDLE and REQ, and mem_gnt_i is ignored outside REQ.
- At most one grant per cycle; the two gnt_o outputs are mutually exclusive, and so are the two rvalid_o outputs.

## Timing

- Reset (asynchronous, any state): state = IDLE; starve_cnt = 0; drop = 0. All outputs are 0, including the mem_* command outputs and the rdata_o outputs.
  - A memory response arriving after reset is ignored, because it lands in IDLE.
- Best-case latency, with mem_gnt_i at the first REQ cycle and mem_rvalid_i one cycle later:
  - cycle 0: req → gnt_o
  - cycle 1: mem_req_o
  - cycle 2: mem_rvalid_i
  - cycle 3: rvalid_o
- The next grant can be issued in cycle 3, the same cycle as rvalid_o, so back-to-back throughput is one transaction per 3 cycles.
- mem_req_o is never dropped or changed before mem_gnt_i, whatever the stall length.
- flush_i coinciding with mem_rvalid_i in WAIT still drops the fetch response.
- Simultaneous if_req_i and ls_req_i with starve_cnt < STARVE_MAX: LS is granted and IF keeps waiting.

## Test plan

- Single load: ls_req_i addr 0x100, memory returns 0xDEADBEEF with mem_gnt_i at cycle 1 and mem_rvalid_i at cycle 2 → ls_gnt_o at cycle 0, ls_rvalid_o at cycle 3 with ls_rdata_o = 0xDEADBEEF, busy_o low at cycle 3.
- Store: ls_we_i = 1, be = 4'b0011, wdata 0x1234 → mem_we_o = 1, mem_be_o = 0011, mem_wdata_o = 0x1234 held through 3 stalled REQ cycles until mem_gnt_i; ls_rvalid_o on the ack.
- Starvation, STARVE_MAX = 4: if_req_i and ls_req_i continuously high → grants LS,LS,LS,LS,IF,LS,…; the IF grant comes after exactly 4 LS grants.
- Flush: fetch granted, flush_i pulsed in WAIT → mem_rvalid_i consumed, if_rvalid_o stays 0, next fetch grant delivers normally. flush_i in IDLE with only if_req_i high → no grant that cycle.
- Async reset while in WAIT, with rst asserted mid-cycle → all outputs 0 immediately; a later stray mem_rvalid_i produces no rvalid_o.
- Dual request at reset exit with starve_cnt = 0 → ls_gnt_o = 1 and if_gnt_o = 0 in the same cycle; never both high.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the unified
// memory port arbiter. The arbiter connects through the slave modport;
// the surrounding core/memory environment uses the master modport.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Pipeline control
    logic            flush_i;

    // Instruction-fetch port
    logic            if_req_i;
    logic [AW-1:0]   if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [DW-1:0]   if_rdata_o;

    // Load/store port
    logic            ls_req_i;
    logic            ls_we_i;
    logic [DW/8-1:0] ls_be_i;
    logic [AW-1:0]   ls_addr_i;
    logic [DW-1:0]   ls_wdata_i;
    logic            ls_gnt_o;
    logic            ls_rvalid_o;
    logic [DW-1:0]   ls_rdata_o;

    // Memory command / response
    logic            mem_req_o;
    logic            mem_we_o;
    logic [DW/8-1:0] mem_be_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;

    logic            busy_o;

    modport slave (
        input  flush_i,
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output busy_o
    );

    modport master (
        output flush_i,
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the
// load/store unit, one transaction at a time (IDLE -> REQ -> WAIT).
//
// Handshakes: a requester holds req and its fields until it sees a
// one-cycle gnt pulse (issued combinationally in IDLE). The memory
// command is held unchanged with mem_req_o high until mem_gnt_i; the
// response arrives as a single mem_rvalid_i cycle in WAIT and is
// forwarded as a one-cycle rvalid pulse on the owner's port the cycle
// after. Load/store has priority; fetch is forced through after
// STARVE_MAX consecutive load/store grants taken while it was waiting.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic            drop;
    logic            owner_if;

    logic            mem_req_q;
    logic            mem_we_q;
    logic [DW/8-1:0] mem_be_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            if_rvalid_q;
    logic [DW-1:0]   if_rdata_q;
    logic            ls_rvalid_q;
    logic [DW-1:0]   ls_rdata_q;

    logic            if_elig;
    logic            starved;
    logic            can_grant;
    logic            ls_win;
    logic            if_win;
    logic            flush_fetch;

    // Arbitration: LS by default, IF once the starvation limit is hit.
    // A fetch presented during a flush is stale and not eligible.
    always_comb begin
        if_elig     = bus.if_req_i && !bus.flush_i;
        starved     = (starve_cnt == CW'(STARVE_MAX));
        can_grant   = (state == S_IDLE) && !rst;
        ls_win      = can_grant && bus.ls_req_i && !(if_elig && starved);
        if_win      = can_grant && if_elig && !ls_win;
        flush_fetch = owner_if && bus.flush_i;
    end

    // Transaction FSM with registered command and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            drop        <= 1'b0;
            owner_if    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ls_win) begin
                        state       <= S_REQ;
                        mem_req_q   <= 1'b1;
                        drop        <= 1'b0;
                        owner_if    <= 1'b0;
                        mem_we_q    <= bus.ls_we_i;
                        mem_be_q    <= bus.ls_be_i;
                        mem_addr_q  <= bus.ls_addr_i;
                        mem_wdata_q <= bus.ls_wdata_i;
                        // Count only grants that made a waiting fetch wait longer.
                        if (bus.if_req_i) begin
                            if (!starved) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (if_win) begin
                        state       <= S_REQ;
                        mem_req_q   <= 1'b1;
                        drop        <= 1'b0;
                        owner_if    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '1;
                        mem_addr_q  <= bus.if_addr_i;
                        mem_wdata_q <= '0;
                        starve_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (flush_fetch) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_fetch) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_rvalid_i) begin
                        state <= S_IDLE;
                        if (owner_if) begin
                            // A flush in the response cycle itself also kills it.
                            if (!(drop || bus.flush_i)) begin
                                if_rvalid_q <= 1'b1;
                                if_rdata_q  <= bus.mem_rdata_i;
                            end
                        end else begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= bus.mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping onto the interface.
    always_comb begin
        bus.if_gnt_o    = if_win;
        bus.ls_gnt_o    = ls_win;
        bus.if_rvalid_o = if_rvalid_q;
        bus.if_rdata_o  = if_rdata_q;
        bus.ls_rvalid_o = ls_rvalid_q;
        bus.ls_rdata_o  = ls_rdata_q;
        bus.mem_req_o   = mem_req_q;
        bus.mem_we_o    = mem_we_q;
        bus.mem_be_o    = mem_be_q;
        bus.mem_addr_o  = mem_addr_q;
        bus.mem_wdata_o = mem_wdata_q;
        bus.busy_o      = (state != S_IDLE);
        dbg_state       = state;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single load, stalled store,
// fetch starvation limit, flush handling, async reset and dual request
// at reset exit. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Entered at the start of the first REQ cycle; returns at the start of
    // the cycle where the owner's rvalid should show.
    task automatic serve(input int stalls, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic e_we,
                         input logic [3:0] e_be, input logic [31:0] e_wd,
                         input bit chk_wd);
        for (int i = 0; i <= stalls; i++) begin
            if (i == stalls) bus.mem_gnt_i = 1'b1;
            settle();
            check("req_held", {31'd0, bus.mem_req_o}, 32'd1);
            check("req_addr", bus.mem_addr_o, e_addr);
            check("req_we", {31'd0, bus.mem_we_o}, {31'd0, e_we});
            check("req_be", {28'd0, bus.mem_be_o}, {28'd0, e_be});
            if (chk_wd) check("req_wdata", bus.mem_wdata_o, e_wd);
            next_cycle();
        end
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rdata;
        settle();
        check("wait_noreq", {31'd0, bus.mem_req_o}, 32'd0);
        check("wait_busy", {31'd0, bus.busy_o}, 32'd1);
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    initial begin
        rst              = 1'b0;
        bus.flush_i      = 1'b0;
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.ls_req_i     = 1'b0;
        bus.ls_we_i      = 1'b0;
        bus.ls_be_i      = '0;
        bus.ls_addr_i    = '0;
        bus.ls_wdata_i   = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        #2 rst = 1'b1;

        // Reset state
        next_cycle();
        settle();
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
        check("rst_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Single load, best-case latency
        bus.ls_req_i  = 1'b1;
        bus.ls_we_i   = 1'b0;
        bus.ls_be_i   = 4'hF;
        bus.ls_addr_i = 32'h100;
        settle();
        check("ld_ls_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
        check("ld_if_gnt", {31'd0, bus.if_gnt_o}, 32'd0);
        next_cycle();
        bus.ls_req_i = 1'b0;
        serve(0, 32'hDEADBEEF, 32'h100, 1'b0, 4'hF, 32'd0, 1'b0);
        settle();
        check("ld_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd1);
        check("ld_rdata", bus.ls_rdata_o, 32'hDEADBEEF);
        check("ld_busy", {31'd0, bus.busy_o}, 32'd0);
        check("ld_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
        next_cycle();
        settle();
        check("ld_rvalid_pulse", {31'd0, bus.ls_rvalid_o}, 32'd0);
        next_cycle();

        // Store held through three stalled REQ cycles
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b1;
        bus.ls_be_i    = 4'b0011;
        bus.ls_addr_i  = 32'h200;
        bus.ls_wdata_i = 32'h1234;
        settle();
        check("st_ls_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
        next_cycle();
        bus.ls_req_i = 1'b0;
        bus.ls_we_i  = 1'b0;
        serve(3, 32'h0, 32'h200, 1'b1, 4'b0011, 32'h1234, 1'b1);
        settle();
        check("st_ack", {31'd0, bus.ls_rvalid_o}, 32'd1);
        check("st_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
        next_cycle();

        // Starvation: both requesting -> LS,LS,LS,LS,IF,LS
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h1000;
        bus.ls_req_i  = 1'b1;
        bus.ls_we_i   = 1'b0;
        bus.ls_be_i   = 4'hF;
        bus.ls_addr_i = 32'h300;
        settle();
        for (int k = 0; k < 6; k++) begin
            bit is_if;
            is_if = (k == 4);
            check($sformatf("sv_if_gnt%0d", k), {31'd0, bus.if_gnt_o}, {31'd0, is_if});
            check($sformatf("sv_ls_gnt%0d", k), {31'd0, bus.ls_gnt_o}, {31'd0, !is_if});
            next_cycle();
            if (k == 5) begin
                bus.if_req_i = 1'b0;
                bus.ls_req_i = 1'b0;
            end
            serve(0, 32'hA000_0000 + k, is_if ? 32'h1000 : 32'h300, 1'b0, 4'hF, 32'd0, 1'b0);
            settle();
            if (is_if) begin
                check($sformatf("sv_if_rv%0d", k), {31'd0, bus.if_rvalid_o}, 32'd1);
                check($sformatf("sv_if_rd%0d", k), bus.if_rdata_o, 32'hA000_0000 + k);
                check($sformatf("sv_ls_rv%0d", k), {31'd0, bus.ls_rvalid_o}, 32'd0);
            end else begin
                check($sformatf("sv_ls_rv%0d", k), {31'd0, bus.ls_rvalid_o}, 32'd1);
                check($sformatf("sv_ls_rd%0d", k), bus.ls_rdata_o, 32'hA000_0000 + k);
                check($sformatf("sv_if_rv%0d", k), {31'd0, bus.if_rvalid_o}, 32'd0);
            end
        end
        next_cycle();

        // Flush pulsed in WAIT drops the fetch response
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h2000;
        settle();
        check("fl1_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        next_cycle();
        bus.mem_gnt_i = 1'b0;
        bus.flush_i   = 1'b1;
        settle();
        check("fl1_busy", {31'd0, bus.busy_o}, 32'd1);
        next_cycle();
        bus.flush_i      = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0_0001;
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        settle();
        check("fl1_no_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
        check("fl1_idle", {31'd0, bus.busy_o}, 32'd0);
        next_cycle();

        // Flush coinciding with the response also drops it
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h2004;
        settle();
        check("fl2_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        next_cycle();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0_0002;
        bus.flush_i      = 1'b1;
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        bus.flush_i      = 1'b0;
        settle();
        check("fl2_no_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
        check("fl2_idle", {31'd0, bus.busy_o}, 32'd0);
        next_cycle();

        // Next fetch delivers normally
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h2008;
        settle();
        check("fl3_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i = 1'b0;
        serve(1, 32'h0000_0013, 32'h2008, 1'b0, 4'hF, 32'd0, 1'b0);
        settle();
        check("fl3_rvalid", {31'd0, bus.if_rvalid_o}, 32'd1);
        check("fl3_rdata", bus.if_rdata_o, 32'h0000_0013);
        next_cycle();

        // Flush in IDLE blocks a lone fetch for that cycle
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h200C;
        bus.flush_i   = 1'b1;
        settle();
        check("fl4_blocked", {31'd0, bus.if_gnt_o}, 32'd0);
        check("fl4_no_ls", {31'd0, bus.ls_gnt_o}, 32'd0);
        next_cycle();
        bus.flush_i = 1'b0;
        settle();
        check("fl4_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i = 1'b0;
        serve(0, 32'h0000_006F, 32'h200C, 1'b0, 4'hF, 32'd0, 1'b0);
        settle();
        check("fl4_rvalid", {31'd0, bus.if_rvalid_o}, 32'd1);
        check("fl4_rdata", bus.if_rdata_o, 32'h0000_006F);
        next_cycle();

        // Asynchronous reset mid-cycle while in WAIT
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h3000;
        settle();
        check("ar_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        next_cycle();
        bus.mem_gnt_i = 1'b0;
        settle();
        check("ar_in_wait", {30'd0, dbg_state}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("ar_state", {30'd0, dbg_state}, 32'd0);
        check("ar_busy", {31'd0, bus.busy_o}, 32'd0);
        check("ar_mem_addr", bus.mem_addr_o, 32'd0);
        check("ar_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("ar_if_rdata", bus.if_rdata_o, 32'd0);
        check("ar_ls_rdata", bus.ls_rdata_o, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0_0003;
        settle();
        check("ar_stray_idle", {31'd0, bus.busy_o}, 32'd0);
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        settle();
        check("ar_stray_if", {31'd0, bus.if_rvalid_o}, 32'd0);
        check("ar_stray_ls", {31'd0, bus.ls_rvalid_o}, 32'd0);
        next_cycle();

        // Dual request held across reset exit: LS first, then IF
        rst           = 1'b1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h1000;
        bus.ls_req_i  = 1'b1;
        bus.ls_we_i   = 1'b0;
        bus.ls_be_i   = 4'hF;
        bus.ls_addr_i = 32'h400;
        settle();
        check("dr_rst_if_gnt", {31'd0, bus.if_gnt_o}, 32'd0);
        check("dr_rst_ls_gnt", {31'd0, bus.ls_gnt_o}, 32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check("dr_ls_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
        check("dr_if_gnt", {31'd0, bus.if_gnt_o}, 32'd0);
        next_cycle();
        bus.ls_req_i = 1'b0;
        serve(0, 32'h0000_0055, 32'h400, 1'b0, 4'hF, 32'd0, 1'b0);
        settle();
        check("dr_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd1);
        check("dr_ls_rdata", bus.ls_rdata_o, 32'h0000_0055);
        check("dr_if_gnt2", {31'd0, bus.if_gnt_o}, 32'd1);
        next_cycle();
        bus.if_req_i = 1'b0;
        serve(0, 32'h0000_0077, 32'h1000, 1'b0, 4'hF, 32'd0, 1'b0);
        settle();
        check("dr_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd1);
        check("dr_if_rdata", bus.if_rdata_o, 32'h0000_0077);
        check("dr_ls_rvalid2", {31'd0, bus.ls_rvalid_o}, 32'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Grants and responses must never collide.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_gnt_o && bus.ls_gnt_o) begin
                check("gnt_exclusive", 32'd1, 32'd0);
            end
            if (bus.if_rvalid_o && bus.ls_rvalid_o) begin
                check("rvalid_exclusive", 32'd1, 32'd0);
            end
        end
    end

endmodule
